// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// PC width, the NOP presented when no instruction is valid, and the PC adder.
package fetch_ctrl_pkg;

    localparam int PC_W  = 16;
    localparam int CNT_W = 16;

    localparam logic [15:0] FETCH_NOP = 16'h0800;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

    // Unsigned 16-bit add; the carry out is dropped so 16'hFFFE + 2 wraps to 0.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] a,
                                                input logic [PC_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Request/response instruction-memory bus between the fetch controller
// (master) and the instruction memory (slave).
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic            mem_en;
    logic [PC_W-1:0] mem_addr;
    logic            mem_stall;
    logic            mem_done;
    logic [15:0]     mem_rdata;

    modport master (
        output mem_en, mem_addr,
        input  mem_stall, mem_done, mem_rdata
    );

    modport slave (
        input  mem_en, mem_addr,
        output mem_stall, mem_done, mem_rdata
    );

endinterface

// File: rtl/fetch_ctrl_perf.sv
// Saturating performance counters for the fetch stage: consumed instructions
// and memory-wait cycles. Only built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl_perf
    import fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_instr,
    input  logic             inc_stall,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_cycles
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (inc_instr) instr_count  <= sat_inc(instr_count);
            if (inc_stall) stall_cycles <= sat_inc(stall_cycles);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, handshakes with a variable-latency
// instruction memory, holds the fetched word for decode, handles redirect/halt.
// Optional counters: define FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = FETCH_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt,
    fetch_ctrl_if.master      mem,
    output logic [15:0]       instr,
    output logic [PC_W-1:0]   pc_out,
    output logic [PC_W-1:0]   pc_plus_two,
    output logic              instr_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  stall_cycles
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic            capture, consume, flush;

    assign pc_inc       = pc_add(pc_q, 16'h0002);
    assign mem.mem_en   = rst && (state_q == S_REQ);
    assign mem.mem_addr = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        consume = 1'b0;
        flush   = 1'b0;

        case (state_q)
            S_REQ: begin
                if (!mem.mem_stall) begin
                    if (mem.mem_done) begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem.mem_done) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    consume = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (mem.mem_done) state_d = S_REQ;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_REQ;
        endcase

        // A request already accepted by memory must be drained before the
        // new target is requested, so only one response is ever in flight.
        if (redirect && state_q != S_HALT) begin
            pc_d    = redirect_pc;
            capture = 1'b0;
            consume = 1'b0;
            flush   = 1'b1;
            case (state_q)
                S_WAIT:  state_d = S_DRAIN;
                S_REQ:   state_d = (!mem.mem_stall && !mem.mem_done) ? S_DRAIN : S_REQ;
                S_DRAIN: state_d = mem.mem_done ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end

        if (halt) begin
            state_d = S_HALT;
            pc_d    = pc_q;
            capture = 1'b0;
            consume = 1'b0;
            flush   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            instr       <= NOP_INSTR;
            pc_out      <= RESET_PC;
            pc_plus_two <= pc_add(RESET_PC, 16'h0002);
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halted  <= (state_d == S_HALT);
            if (capture) begin
                instr       <= mem.mem_rdata;
                pc_out      <= pc_q;
                pc_plus_two <= pc_inc;
                instr_valid <= 1'b1;
            end else if (consume || flush) begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic inc_stall;

    assign inc_stall = (state_q == S_REQ && mem.mem_stall) ||
                       (state_q == S_WAIT) || (state_q == S_DRAIN);

    fetch_ctrl_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .inc_instr    (consume),
        .inc_stall    (inc_stall),
        .instr_count  (instr_count),
        .stall_cycles (stall_cycles)
    );
`else
    assign instr_count  = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: behavioural variable-latency memory plus
// a scoreboard of expected (pc, instr) presentations to decode.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, redirect, halt;
    logic [15:0] redirect_pc;
    logic [15:0] instr, pc_out, pc_plus_two, instr_count, stall_cycles;
    logic        instr_valid, halted;

    always #5 clk = ~clk;

    fetch_ctrl_if mif ();

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .mem          (mif.master),
        .instr        (instr),
        .pc_out       (pc_out),
        .pc_plus_two  (pc_plus_two),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .instr_count  (instr_count),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] acc_q[$];
    int          pres_cyc[$];
    int          n_cmp = 0, n_bad = 0;
    int          en_cnt, pres_cnt, cyc;
    bit          prev_valid = 1'b0;

    // memory model state
    int          lat = 0, stall_left = 0, cnt = 0;
    bit          busy = 1'b0, dead_next = 1'b0;
    bit          drove_done = 1'b0, accepted_prev = 1'b0, stalled_prev = 1'b0;
    logic [15:0] raddr = '0, addr_prev = '0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input logic [15:0] a);
        return (a == 16'h0000) ? 16'hA123 : (a ^ 16'h5A5A);
    endfunction

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = word(pc);
        sb.push_back(e);
    endtask

    // One clock: memory answers for this cycle, edge, then retire and monitor.
    task automatic tick();
        #1;
        drove_done    = 1'b0;
        accepted_prev = 1'b0;
        stalled_prev  = 1'b0;
        mif.mem_stall = 1'b0;
        mif.mem_done  = 1'b0;
        mif.mem_rdata = 16'h0000;
        if (mif.mem_en) en_cnt++;
        if (busy) begin
            chk("one_outstanding", {15'd0, mif.mem_en}, 16'd0);
            if (cnt == 0) begin
                mif.mem_done  = 1'b1;
                mif.mem_rdata = dead_next ? 16'hDEAD : word(raddr);
                dead_next     = 1'b0;
                drove_done    = 1'b1;
            end
        end else if (mif.mem_en) begin
            if (stall_left > 0) begin
                mif.mem_stall = 1'b1;
                stalled_prev  = 1'b1;
            end else begin
                accepted_prev = 1'b1;
                addr_prev     = mif.mem_addr;
                acc_q.push_back(mif.mem_addr);
                if (lat == 0) begin
                    mif.mem_done  = 1'b1;
                    mif.mem_rdata = word(mif.mem_addr);
                    drove_done    = 1'b1;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (!rst) begin
            busy = 1'b0;
        end else begin
            if (drove_done) busy = 1'b0;
            else if (busy) cnt--;
            if (accepted_prev && lat > 0) begin
                busy  = 1'b1;
                cnt   = lat - 1;
                raddr = addr_prev;
            end
            if (stalled_prev) stall_left--;
        end

        if (instr_valid === 1'b1 && !prev_valid) begin
            pres_cnt++;
            pres_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_instr", {15'd0, instr_valid}, 16'd0);
            end else begin
                exp_t        e;
                logic [15:0] p2;
                e  = sb.pop_front();
                p2 = e.pc + 16'd2;
                chk("instr", instr, e.ins);
                chk("pc_out", pc_out, e.pc);
                chk("pc_plus_two", pc_plus_two, p2);
            end
        end
        prev_valid = (instr_valid === 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        redirect_pc = 16'h0000;
        dead_next = 1'b0; stall_left = 0;
        tick();
        tick();
        chk("mem_en_in_reset", {15'd0, mif.mem_en}, 16'd0);
        rst = 1'b1;
        acc_q.delete();
        pres_cyc.delete();
        en_cnt = 0; pres_cnt = 0; cyc = 0;
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (pres_cnt < n && k < budget) begin
            tick();
            k++;
        end
        stall = 1'b1;
        chk("presented", 16'(pres_cnt), 16'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.mem_stall = 1'b0;
        mif.mem_done  = 1'b0;
        mif.mem_rdata = 16'h0000;

        // reset state
        do_reset();
        chk("rst_instr", instr, 16'h0800);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_pc_out", pc_out, 16'h0000);
        chk("rst_pc2", pc_plus_two, 16'h0002);
        chk("rst_icnt", instr_count, 16'd0);
        chk("rst_scnt", stall_cycles, 16'd0);

        // zero-wait memory: one instruction every two cycles
        lat = 0;
        push_exp(16'h0000); push_exp(16'h0002); push_exp(16'h0004);
        run_until(3, 40);
        chk("zw_nacc", 16'(acc_q.size()), 16'd3);
        if (acc_q.size() == 3) begin
            chk("zw_addr0", acc_q[0], 16'h0000);
            chk("zw_addr1", acc_q[1], 16'h0002);
            chk("zw_addr2", acc_q[2], 16'h0004);
        end
        if (pres_cyc.size() == 3) begin
            chk("zw_rate01", 16'(pres_cyc[1] - pres_cyc[0]), 16'd2);
            chk("zw_rate12", 16'(pres_cyc[2] - pres_cyc[1]), 16'd2);
        end

        // memory stalls 2 cycles, then 3 cycles of latency
        do_reset();
        lat = 3; stall_left = 2;
        push_exp(16'h0000);
        run_until(1, 40);
        chk("lat_en_cycles", 16'(en_cnt), 16'd3);
        chk("lat_nacc", 16'(acc_q.size()), 16'd1);
        chk("lat_stall_cycles", stall_cycles, PERF ? 16'd5 : 16'd0);

        // decode stall holds the instruction, no new request
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_instr", instr, 16'hA123);
            chk("hold_pc_out", pc_out, 16'h0000);
            chk("hold_valid", {15'd0, instr_valid}, 16'd1);
        end
        chk("hold_no_req", 16'(en_cnt), 16'd3);
        lat = 0;
        push_exp(16'h0002);
        stall = 1'b0;
        run_until(2, 30);
        chk("release_addr", acc_q[acc_q.size()-1], 16'h0002);
        chk("icnt_after_consume", instr_count, PERF ? 16'd1 : 16'd0);

        // redirect in WAIT, stale 16'hDEAD must be discarded
        do_reset();
        lat = 3;
        tick();
        chk("rd_first_acc", 16'(acc_q.size()), 16'd1);
        redirect = 1'b1; redirect_pc = 16'h0100; dead_next = 1'b1;
        tick();
        redirect = 1'b0;
        chk("rd_valid_low", {15'd0, instr_valid}, 16'd0);
        push_exp(16'h0100);
        run_until(1, 40);
        chk("rd_nacc", 16'(acc_q.size()), 16'd2);
        if (acc_q.size() >= 2) chk("rd_new_addr", acc_q[1], 16'h0100);

        // PC wrap at 16'hFFFE, then halt with coincident redirect
        do_reset();
        lat = 0;
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        push_exp(16'hFFFE); push_exp(16'h0000);
        run_until(2, 30);
        if (acc_q.size() == 3) begin
            chk("wrap_addr_fffe", acc_q[1], 16'hFFFE);
            chk("wrap_addr_0000", acc_q[2], 16'h0000);
        end else begin
            chk("wrap_nacc", 16'(acc_q.size()), 16'd3);
        end
        halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
        tick();
        halt = 1'b0; stall = 1'b0;
        chk("halt_halted", {15'd0, halted}, 16'd1);
        chk("halt_valid", {15'd0, instr_valid}, 16'd0);
        chk("halt_instr", instr, 16'h0800);
        en_cnt = 0;
        for (int i = 0; i < 8; i++) tick();
        redirect = 1'b0;
        chk("halt_no_req", 16'(en_cnt), 16'd0);
        chk("halt_pc_frozen", mif.mem_addr, 16'h0000);
        chk("halt_sticky", {15'd0, halted}, 16'd1);

        // reset in the middle of WAIT
        do_reset();
        lat = 5;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("mrst_instr", instr, 16'h0800);
        chk("mrst_valid", {15'd0, instr_valid}, 16'd0);
        chk("mrst_pc_out", pc_out, 16'h0000);
        chk("mrst_pc", mif.mem_addr, 16'h0000);
        chk("mrst_icnt", instr_count, 16'd0);
        chk("mrst_scnt", stall_cycles, 16'd0);
        rst = 1'b1;
        lat = 0;
        acc_q.delete();
        pres_cnt = 0;
        push_exp(16'h0000);
        run_until(1, 20);
        if (acc_q.size() >= 1) chk("mrst_first_addr", acc_q[0], 16'h0000);

        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
